sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Round-robin arbiter that shares one bank of set/reset flag cells between NUM_REQ requesters.
- Each cycle, at most one requester's set/clear masks are applied to the flag bank.
- Q/Qb complement outputs behave as an array of SR flip-flops with a deterministic, non-X conflict policy.
- Sits between command sources (controllers, status producers) and the shared status flag register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_FLAGS, 8, number of SR flag cells in the bank
- IDX_W, 2, width of requester index (clog2(NUM_REQ))
- RESET_VAL, all ones (NUM_FLAGS bits), value loaded into Q on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester command valid
- req_lock  in  NUM_REQ  per-requester request to keep ownership on following cycles
- req_set  in  NUM_REQ*NUM_FLAGS  set masks; requester i at bits [i*NUM_FLAGS +: NUM_FLAGS]
- req_clr  in  NUM_REQ*NUM_FLAGS  clear masks; same packing as req_set
- err_clr  in  1  clears conflict_err
- grant  out  NUM_REQ  registered one-hot; grant[i]=1 means requester i's command was applied at the last edge
- grant_id  out  IDX_W  index of the last winner; holds value when idle
- Q  out  NUM_FLAGS  flag bank state
- Qb  out  NUM_FLAGS  always exactly ~Q, never X
- conflict_err  out  1  sticky flag: a set/clear conflict occurred

Behaviour:
- Clock and reset: single clock domain. reset is synchronous, active-high and overrides everything.
  - On a reset edge: Q=RESET_VAL, Qb=~RESET_VAL, grant=0, grant_id=0, conflict_err=0, rr pointer=0, owner invalid.
  - No command is applied on a reset edge, even if req is asserted.
- Arbitration: evaluated combinationally from req and the pointer; results are registered on the edge.
  - Search order starts at requester ptr and continues ptr+1 ... wrapping modulo NUM_REQ. The first requester with req=1 wins.
  - After reset ptr=0, so requester 0 has highest priority.
  - After a win by requester w (no lock held), ptr = (w+1) mod NUM_REQ.
  - If no req is asserted: grant=0, ptr unchanged, Q unchanged, grant_id holds its value.
- Lock: owner state is OWN_NONE or OWN_i.
  - If the winner w has req_lock[w]=1, the next state is OWN_w.
  - While in OWN_w and req[w]=1: w wins unconditionally and ptr does not advance.
  - OWN_w exits to OWN_NONE on the edge where req[w]=0 or req_lock[w]=0. A command presented with req[w]=1 on that edge is still applied.
  - ptr then becomes (w+1) mod NUM_REQ.
- Flag update: applied on the same edge as the grant, so Q changes in the same cycle grant[w] is first visible.
  - Latency: 1 cycle from req to grant and Q.
  - Per bit b, using winner masks S=req_set[w][b] and R=req_clr[w][b]:
    - S=0, R=0: Q holds
    - S=0, R=1: Q=0
    - S=1, R=0: Q=1
    - S=1, R=1: Q holds and conflict_err is set to 1
  - Qb is registered alongside Q and is always ~Q.
- conflict_err:
  - Sticky; cleared only by reset or by err_clr=1 on an edge.
  - If err_clr and a new conflict occur on the same edge, the new conflict wins: conflict_err=1.
- Handshake:
  - A requester holds req, set and clr stable until it sees grant[i]=1.
  - It deasserts req in that same cycle if it does not want a repeat. If req stays high, the command is re-arbitrated and may be applied again; set/clear are idempotent.
- Masks from non-winning requesters are ignored. Masks with req=0 are don't-care.

Test Plan:
- Reset, with all requesters driving req=1 during reset -> after the edge: Q=8'hFF, Qb=8'h00, grant=0, conflict_err=0. Q is unchanged while reset stays high.
- Start from Q=8'hFF. req[0]=1 with clr=8'h0F -> next cycle grant=4'b0001, grant_id=0, Q=8'hF0, Qb=8'h0F.
- req=4'b1111 held continuously, each requester with a distinct set bit (0x01, 0x02, 0x04, 0x08), from Q=0 -> grants 0001, 0010, 0100, 1000 on consecutive cycles, then wraps to 0001; Q=8'h0F after 4 cycles.
- From Q=8'h00, req[1] with set=8'h81 and clr=8'h01 -> Q=8'h80, conflict_err=1. It stays 1 over idle cycles, then err_clr=1 drives it to 0.
- req[2] with req_lock=1 while req[0] and req[1] are pending -> grant=0100 for 3 cycles while the lock is held. Drop the lock -> next grant goes to requester 0 (ptr=3 with req[3]=0, wrapping to 0), then requester 1.
- reset asserted on the cycle req[3] with set=8'hFF is presented, from Q=8'h00 -> Q=RESET_VAL, grant=0. Deassert reset with req[3] still high -> requester 3 is granted next cycle.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter that lets one requester per cycle
// apply set/clear masks to a shared bank of SR flag cells.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   req          per-requester command valid
//   req_lock     per-requester request to keep ownership
//   req_set      packed set masks, requester i at [i*NUM_FLAGS +: NUM_FLAGS]
//   req_clr      packed clear masks, same packing
//   err_clr      clears conflict_err
//   grant        registered one-hot of the requester applied last edge
//   grant_id     index of the last winner (holds when idle)
//   Q / Qb       flag bank state and its complement
//   conflict_err sticky set/clear conflict indicator
module sr_flag_arbiter #(
    parameter int                   NUM_REQ   = 4,
    parameter int                   NUM_FLAGS = 8,
    parameter int                   IDX_W     = 2,
    parameter logic [NUM_FLAGS-1:0] RESET_VAL = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*NUM_FLAGS-1:0] req_set,
    input  logic [NUM_REQ*NUM_FLAGS-1:0] req_clr,
    input  logic                         err_clr,
    output logic [NUM_REQ-1:0]           grant,
    output logic [IDX_W-1:0]             grant_id,
    output logic [NUM_FLAGS-1:0]         Q,
    output logic [NUM_FLAGS-1:0]         Qb,
    output logic                         conflict_err
);

    // (a + k) mod NUM_REQ, for a < NUM_REQ and k <= NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] a,
        input int               k
    );
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Owner state: r_own_vld=0 is OWN_NONE, otherwise OWN_<r_own_id>
    logic                 r_own_vld;
    logic [IDX_W-1:0]     r_own_id;
    logic [IDX_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_grant_id;
    logic [NUM_FLAGS-1:0] r_q;
    logic [NUM_FLAGS-1:0] r_qb;
    logic                 r_err;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win_id;
    logic                 w_own_vld_nxt;
    logic [IDX_W-1:0]     w_own_id_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [NUM_FLAGS-1:0] w_s;
    logic [NUM_FLAGS-1:0] w_r;
    logic [NUM_FLAGS-1:0] w_q_nxt;
    logic                 w_conf;
    logic                 w_err_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_own_vld  <= 1'b0;
            r_own_id   <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_q        <= RESET_VAL;
            r_qb       <= ~RESET_VAL;
            r_err      <= 1'b0;
        end else begin
            r_own_vld  <= w_own_vld_nxt;
            r_own_id   <= w_own_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            if (w_found) r_grant_id <= w_win_id;
            r_q        <= w_q_nxt;
            r_qb       <= ~w_q_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state: arbitration and ownership
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_win_id = wrap_add(r_ptr, k);
            end
        end
        // A held lock overrides the rotating search
        if (r_own_vld && req[r_own_id]) begin
            w_found  = 1'b1;
            w_win_id = r_own_id;
        end
        w_own_vld_nxt = w_found && req_lock[w_win_id];
        w_own_id_nxt  = w_found ? w_win_id : r_own_id;
        // While locked the winner repeats, so w+1 leaves ptr unchanged
        w_ptr_nxt     = w_found ? wrap_add(w_win_id, 1) : r_ptr;
        w_grant_nxt   = '0;
        if (w_found) w_grant_nxt[w_win_id] = 1'b1;
    end

    // Flag bank and error update from the winner's masks
    always_comb begin
        w_s = '0;
        w_r = '0;
        if (w_found) begin
            w_s = req_set[w_win_id*NUM_FLAGS +: NUM_FLAGS];
            w_r = req_clr[w_win_id*NUM_FLAGS +: NUM_FLAGS];
        end
        // S=R=1 holds the bit; only exclusive set/clear change it
        w_q_nxt   = (r_q & ~(w_r & ~w_s)) | (w_s & ~w_r);
        w_conf    = |(w_s & w_r);
        w_err_nxt = w_conf ? 1'b1 : (err_clr ? 1'b0 : r_err);
    end

    // Outputs
    always_comb begin
        grant        = r_grant;
        grant_id     = r_grant_id;
        Q            = r_q;
        Qb           = r_qb;
        conflict_err = r_err;
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed vector bench for sr_flag_arbiter.
// One vector = one clock edge; outputs sampled 1 time unit after the edge.
module tb_sr_flag_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] set;
        logic [31:0] clr;
        logic        ec;
        logic [3:0]  g;
        logic [1:0]  id;
        logic [7:0]  q;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [31:0] req_set;
    logic [31:0] req_clr;
    logic        err_clr;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic [7:0]  Q;
    logic [7:0]  Qb;
    logic        conflict_err;

    int n_pass = 0;
    int n_total = 0;

    sr_flag_arbiter #(
        .NUM_REQ  (4),
        .NUM_FLAGS(8),
        .IDX_W    (2),
        .RESET_VAL(8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_lock    (req_lock),
        .req_set     (req_set),
        .req_clr     (req_clr),
        .err_clr     (err_clr),
        .grant       (grant),
        .grant_id    (grant_id),
        .Q           (Q),
        .Qb          (Qb),
        .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run(input string tag, input vec_t v);
        reset    = v.rst;
        req      = v.req;
        req_lock = v.lock;
        req_set  = v.set;
        req_clr  = v.clr;
        err_clr  = v.ec;
        @(posedge clk);
        #1;
        chk({tag, " grant"}, {4'h0, grant}, {4'h0, v.g});
        chk({tag, " grant_id"}, {6'h0, grant_id}, {6'h0, v.id});
        chk({tag, " Q"}, Q, v.q);
        chk({tag, " Qb"}, Qb, ~v.q);
        chk({tag, " err"}, {7'h0, conflict_err}, {7'h0, v.err});
    endtask

    vec_t tbl[18];

    initial begin
        reset = 1'b1; req = '0; req_lock = '0;
        req_set = '0; req_clr = '0; err_clr = 1'b0;
        @(negedge clk);

        // reset with all requesters active; reset held
        tbl[0]  = '{1, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 4'h0, 0, 8'hFF, 0};
        tbl[1]  = '{1, 4'hF, 4'h0, 32'h0, 32'hFFFFFFFF, 0, 4'h0, 0, 8'hFF, 0};
        // req0 clears low nibble
        tbl[2]  = '{0, 4'h1, 4'h0, 32'h0, 32'h0000000F, 0, 4'h1, 0, 8'hF0, 0};
        tbl[3]  = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 0, 8'hF0, 0};
        // ptr=1: req3 wins, clears all, ptr -> 0
        tbl[4]  = '{0, 4'h8, 4'h0, 32'h0, 32'hFF000000, 0, 4'h8, 3, 8'h00, 0};
        // round robin with all requesting
        tbl[5]  = '{0, 4'hF, 4'h0, 32'h08040201, 32'h0, 0, 4'h1, 0, 8'h01, 0};
        tbl[6]  = '{0, 4'hF, 4'h0, 32'h08040201, 32'h0, 0, 4'h2, 1, 8'h03, 0};
        tbl[7]  = '{0, 4'hF, 4'h0, 32'h08040201, 32'h0, 0, 4'h4, 2, 8'h07, 0};
        tbl[8]  = '{0, 4'hF, 4'h0, 32'h08040201, 32'h0, 0, 4'h8, 3, 8'h0F, 0};
        tbl[9]  = '{0, 4'hF, 4'h0, 32'h08040201, 32'h0, 0, 4'h1, 0, 8'h0F, 0};
        // req1 clears, then set/clear conflict on bit 0
        tbl[10] = '{0, 4'h2, 4'h0, 32'h0, 32'h0000FF00, 0, 4'h2, 1, 8'h00, 0};
        tbl[11] = '{0, 4'h2, 4'h0, 32'h00008100, 32'h00000100, 0, 4'h2, 1, 8'h80, 1};
        tbl[12] = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 1, 8'h80, 1};
        tbl[13] = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 1, 8'h80, 1};
        tbl[14] = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 1, 8'h80, 0};
        // err_clr and new conflict on the same edge: conflict wins
        tbl[15] = '{0, 4'h2, 4'h0, 32'h00000100, 32'h00000100, 1, 4'h2, 1, 8'h80, 1};
        tbl[16] = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 1, 8'h80, 0};
        // ptr=2 -> req0 wins; req1 and idle req3 masks ignored
        tbl[17] = '{0, 4'h3, 4'h0, 32'hFF00FF00, 32'h00000080, 0, 4'h1, 0, 8'h00, 0};

        for (int i = 0; i < 18; i++) run($sformatf("v%0d", i), tbl[i]);

        // lock: req1 alone to move ptr to 2
        run("lk0", '{0, 4'h2, 4'h0, 32'h0, 32'h0, 0, 4'h2, 1, 8'h00, 0});
        // req2 locks with req0/req1 pending
        run("lk1", '{0, 4'h7, 4'h4, 32'h00040000, 32'h0, 0, 4'h4, 2, 8'h04, 0});
        run("lk2", '{0, 4'h7, 4'h4, 32'h00040000, 32'h0, 0, 4'h4, 2, 8'h04, 0});
        run("lk3", '{0, 4'h7, 4'h4, 32'h00040000, 32'h0, 0, 4'h4, 2, 8'h04, 0});
        // lock dropped with req2 still high: command applied on exit edge
        run("lk4", '{0, 4'h7, 4'h0, 32'h00040000, 32'h0, 0, 4'h4, 2, 8'h04, 0});
        // ptr=3, req3 idle -> wraps to req0, then req1
        run("lk5", '{0, 4'h3, 4'h0, 32'h0, 32'h0, 0, 4'h1, 0, 8'h04, 0});
        run("lk6", '{0, 4'h2, 4'h0, 32'h0, 32'h0, 0, 4'h2, 1, 8'h04, 0});

        // req3 clears (with a bit-0 conflict) -> Q=00, err=1
        run("rs0", '{0, 4'h8, 4'h0, 32'h01000000, 32'hFF000000, 0, 4'h8, 3, 8'h00, 1});
        // reset while req3 presents set=FF: nothing applied
        run("rs1", '{1, 4'h8, 4'h0, 32'hFF000000, 32'h0, 0, 4'h0, 0, 8'hFF, 0});
        // reset released, req3 still high: granted next edge
        run("rs2", '{0, 4'h8, 4'h0, 32'hFF000000, 32'h0, 0, 4'h8, 3, 8'hFF, 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
